// File: rtl/bitstream_fifo_p.sv
// bitstream_fifo_p: bit-granular FIFO. Fixed-width words are written in,
// and variable-length bit fields (0..MAX_LEN bits) are read out through a
// 2-stage registered result pipeline.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   flush           synchronous clear of pointers and occupancy
//   pushin, datain  write strobe and word (datain[0] is the oldest bit)
//   pushready       a full word fits in the buffer
//   reqin, reqlen   read request strobe and field length
//   peek            read without consuming bits
//   pushout         result valid, 2 cycles after the request cycle
//   lenout, dataout result length and field (bit 0 oldest, zero above lenout)
//   bitcount        current occupancy in bits
//   ovf_err/udf_err sticky dropped-push / dropped-request flags
//   clr_err         clears both sticky flags (a same-cycle error wins)
module bitstream_fifo_p #(
  parameter int IN_W    = 32,
  parameter int DEPTH   = 32,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = $clog2(IN_W * DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               pushin,
  input  logic [IN_W-1:0]    datain,
  output logic               pushready,
  input  logic               reqin,
  input  logic [LEN_W-1:0]   reqlen,
  input  logic               peek,
  output logic               pushout,
  output logic [LEN_W-1:0]   lenout,
  output logic [MAX_LEN-1:0] dataout,
  output logic [CNT_W-1:0]   bitcount,
  output logic               ovf_err,
  output logic               udf_err,
  input  logic               clr_err
);

  localparam int CAP   = IN_W * DEPTH;
  localparam int PTR_W = $clog2(CAP);
  localparam int WP_W  = $clog2(DEPTH);
  localparam int IB_W  = $clog2(IN_W);
  localparam logic [CNT_W-1:0] PUSH_LIM = CNT_W'(CAP - IN_W);

  logic [CAP-1:0]     buf_q;
  logic [WP_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [LEN_W-1:0]   s1_len_q, s1_len_d, s2_len_q, s2_len_d;
  logic [MAX_LEN-1:0] s1_dat_q, s1_dat_d, s2_dat_q, s2_dat_d;
  logic               ovf_q, ovf_d, udf_q, udf_d;

  logic [LEN_W-1:0]   eff_len_s;
  logic [MAX_LEN-1:0] field_s;
  logic               push_acc_s, req_acc_s;

  // Over-long requests are clamped to MAX_LEN before any other use.
  assign eff_len_s  = (reqlen > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : reqlen;
  assign pushready  = (count_q <= PUSH_LIM);
  // Both acceptance decisions use pre-edge occupancy; flush suppresses both.
  assign push_acc_s = pushin & pushready & ~flush;
  assign req_acc_s  = reqin & (CNT_W'(eff_len_s) <= count_q) & ~flush;

  // Field extraction: pointer arithmetic wraps mod CAP, so a field
  // straddling the end of the buffer comes out contiguous.
  always_comb begin
    field_s = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(eff_len_s)) field_s[i] = buf_q[rd_ptr_q + PTR_W'(i)];
      else                     field_s[i] = 1'b0;
    end
  end

  // Next-state logic for pointers, occupancy, pipeline and error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Invalid stages carry zeros so outputs never hold stale data.
    s1_vld_d = req_acc_s;
    s1_len_d = req_acc_s ? eff_len_s : '0;
    s1_dat_d = req_acc_s ? field_s : '0;
    s2_vld_d = s1_vld_q;
    s2_len_d = s1_len_q;
    s2_dat_d = s1_dat_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc_s) wr_ptr_d = wr_ptr_q + WP_W'(1);
      else            wr_ptr_d = wr_ptr_q;
      if (req_acc_s && !peek) rd_ptr_d = rd_ptr_q + PTR_W'(eff_len_s);
      else                    rd_ptr_d = rd_ptr_q;
      count_d = count_q
              + (push_acc_s ? CNT_W'(IN_W) : CNT_W'(0))
              - ((req_acc_s && !peek) ? CNT_W'(eff_len_s) : CNT_W'(0));
    end
    // Error events take precedence over a same-cycle clear.
    ovf_d = (ovf_q & ~clr_err) | (pushin & ~pushready & ~flush);
    udf_d = (udf_q & ~clr_err) | (reqin & ~req_acc_s & ~flush);
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      s1_vld_q <= 1'b0;
      s1_len_q <= '0;
      s1_dat_q <= '0;
      s2_vld_q <= 1'b0;
      s2_len_q <= '0;
      s2_dat_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      s1_vld_q <= s1_vld_d;
      s1_len_q <= s1_len_d;
      s1_dat_q <= s1_dat_d;
      s2_vld_q <= s2_vld_d;
      s2_len_q <= s2_len_d;
      s2_dat_q <= s2_dat_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Buffer storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push_acc_s) buf_q[{wr_ptr_q, {IB_W{1'b0}}} +: IN_W] <= datain;
    else            buf_q <= buf_q;
  end

  assign pushout  = s2_vld_q;
  assign lenout   = s2_len_q;
  assign dataout  = s2_dat_q;
  assign bitcount = count_q;
  assign ovf_err  = ovf_q;
  assign udf_err  = udf_q;

endmodule

// File: tb/tb_bitstream_fifo_p.sv
// Self-checking bench for bitstream_fifo_p. The reference model holds the
// FIFO contents as a queue of bits and the in-flight results as a queue of
// (due cycle, length, data) entries.
module tb_bitstream_fifo_p;
  localparam int IN_W = 32, DEPTH = 32, MAX_LEN = 16;
  localparam int LEN_W = 5, CNT_W = 11;
  localparam int CAP = IN_W * DEPTH;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, pushin = 1'b0, reqin = 1'b0;
  logic peek = 1'b0, clr_err = 1'b0;
  logic [IN_W-1:0] datain = '0;
  logic [LEN_W-1:0] reqlen = '0;
  logic pushready, pushout, ovf_err, udf_err;
  logic [LEN_W-1:0] lenout;
  logic [MAX_LEN-1:0] dataout;
  logic [CNT_W-1:0] bitcount;

  bitstream_fifo_p #(.IN_W(IN_W), .DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .flush(flush), .pushin(pushin), .datain(datain),
    .pushready(pushready), .reqin(reqin), .reqlen(reqlen), .peek(peek),
    .pushout(pushout), .lenout(lenout), .dataout(dataout),
    .bitcount(bitcount), .ovf_err(ovf_err), .udf_err(udf_err),
    .clr_err(clr_err));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  bit mq[$];
  int rdue[$], rlen[$];
  logic [MAX_LEN-1:0] rdat[$];
  logic m_ovf = 1'b0, m_udf = 1'b0;
  int nreads;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic ev;
    int el;
    logic [MAX_LEN-1:0] ed;
    ev = 1'b0; el = 0; ed = '0;
    if (rdue.size() > 0 && rdue[0] == cyc) begin
      ev = 1'b1;
      el = rlen.pop_front();
      ed = rdat.pop_front();
      void'(rdue.pop_front());
    end
    chk("pushout", 32'(pushout), 32'(ev));
    chk("lenout", 32'(lenout), 32'(el));
    chk("dataout", 32'(dataout), 32'(ed));
    chk("bitcount", 32'(bitcount), 32'(mq.size()));
    chk("pushready", 32'(pushready), 32'(mq.size() <= CAP - IN_W));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    chk("udf_err", 32'(udf_err), 32'(m_udf));
  endtask

  task automatic model_clear();
    mq.delete(); rdue.delete(); rlen.delete(); rdat.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  // One clock: drive inputs, apply the model on the edge, check at negedge.
  task automatic step(input logic p, input logic [IN_W-1:0] d, input logic r,
                      input int l, input logic pk, input logic fl, input logic ce);
    int pre, eff;
    logic push_ok, oset, uset;
    logic [MAX_LEN-1:0] f;
    pushin = p; datain = d; reqin = r; reqlen = LEN_W'(l); peek = pk;
    flush = fl; clr_err = ce;
    @(posedge clk);
    cyc++;
    pre = mq.size();
    eff = (l > MAX_LEN) ? MAX_LEN : l;
    push_ok = p && !fl && (pre <= CAP - IN_W);
    oset = p && !fl && !push_ok;
    uset = 1'b0;
    if (r && !fl) begin
      if (eff <= pre) begin
        f = '0;
        for (int i = 0; i < eff; i++) f[i] = mq[i];
        rdue.push_back(cyc + 1); rlen.push_back(eff); rdat.push_back(f);
        if (!pk) for (int i = 0; i < eff; i++) void'(mq.pop_front());
      end else uset = 1'b1;
    end
    if (push_ok) for (int i = 0; i < IN_W; i++) mq.push_back(d[i]);
    if (fl) mq.delete();
    m_ovf = (m_ovf & ~ce) | oset;
    m_udf = (m_udf & ~ce) | uset;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all();
    chk("reset_pushready", 32'(pushready), 32'd1);
    idle(1);

    // DEADBEEF with field lengths 4, 8, 4
    step(1'b1, 32'hDEADBEEF, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 4, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 8, 1'b0, 1'b0, 1'b0);
    chk("first_field", 32'(dataout), 32'hF);
    step(1'b0, '0, 1'b1, 4, 1'b0, 1'b0, 1'b0);
    chk("second_field", 32'(dataout), 32'hEE);
    idle(2);
    chk("deadbeef_count", 32'(bitcount), 32'd16);

    // Zero-length and over-long requests
    step(1'b0, '0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b1, 31, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Fill to capacity, overflow, set-wins, clear
    step(1'b0, '0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(bitcount), 32'd1024);
    chk("full_pushready", 32'(pushready), 32'd0);
    step(1'b1, $urandom, 1'b1, 8, 1'b0, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(ovf_err), 32'd0);

    // Empty buffer: push and request together
    step(1'b0, '0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b1, $urandom, 1'b1, 4, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("udf_count", 32'(bitcount), 32'd32);
    chk("udf_flag", 32'(udf_err), 32'd1);
    step(1'b0, '0, 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Wrap: 85 reads of 12 bits bring rd_ptr to 1020, then read across the end
    step(1'b0, '0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    nreads = 0;
    for (int k = 0; k < 1000 && nreads < 85; k++) begin
      if (mq.size() >= 12) nreads++;
      step(mq.size() < 64, $urandom, mq.size() >= 12, 12, 1'b0, 1'b0, 1'b0);
    end
    chk("wrap_reads", 32'(nreads), 32'd85);
    while (mq.size() < 12) step(1'b1, $urandom, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 12, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Peek twice then consume
    step(1'b0, '0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b1, $urandom, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 8, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 8, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 8, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("peek_count", 32'(bitcount), 32'd24);

    // Reset with two results in flight
    step(1'b0, '0, 1'b1, 4, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 4, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    model_clear();
    check_all();
    #1 rst = 1'b0;
    idle(3);

    // Flush with one result in flight
    step(1'b1, $urandom, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 4, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("flush_result", 32'(pushout), 32'd1);
    chk("flush_count", 32'(bitcount), 32'd0);
    idle(1);

    // Randomized traffic
    for (int k = 0; k < 800; k++)
      step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, MAX_LEN), $urandom_range(0, 3) == 0,
           $urandom_range(0, 79) == 0, $urandom_range(0, 15) == 0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
